zircon_led_pwm: RTL and testbench
=================================

// Module: zircon_led_pwm
// PURPOSE
// - Avalon-MM slave LED controller with LED_W independent channels, replacing the fixed 8-bit on/off LED peripheral.
// - Per-channel PWM brightness, a global blink gate and selectable output polarity.
// - Sits on the Qsys bus and drives LED pins through a conduit (coe_led).
// PARAMETERS
// - LED_W    8   number of LED channels; must satisfy LED_W <= 2**ADDR_W - 4
// - PWM_W    8   duty register and PWM counter width
// - BLINK_W  24  blink period register and counter width
// - ADDR_W   4   avs_address width in words
// PORTS
// - csi_clk        in   1       system clock
// - rsi_reset_n    in   1       asynchronous, active-low reset
// - avs_address    in   ADDR_W  word address
// - avs_write      in   1       write strobe, single cycle, no waitrequest
// - avs_writedata  in   32      write data; bits above each field width ignored
// - coe_led        out  LED_W   LED pins, registered
// BEHAVIOUR
// - Register map (word address):
//   - 0 CTRL: [0] EN, [1] MODE (0 static, 1 PWM), [2] BLINK_EN, [3] INV
//   - 1 MASK: [LED_W-1:0], per-channel on/off
//   - 2 BLINK: [BLINK_W-1:0], half-period in clocks
//   - 3 reserved
//   - 4+i DUTY[i]: [PWM_W-1:0], for i < LED_W
// - Writes to unmapped or reserved addresses are ignored.
// - Reset (async assert, sync release): all registers 0, pwm_cnt 0, blink_cnt 0, blink_ph 1, coe_led 0.
// - Register write takes effect at the clock edge where avs_write=1; coe_led reflects it one edge later (2-edge latency).
// - pwm_cnt: PWM_W-bit free-running up-counter, increments every clock while EN=1, wraps to 0 from all-ones.
// - blink_cnt: increments while EN=1 && BLINK_EN=1 && BLINK!=0.
//   - When blink_cnt == BLINK-1: blink_cnt clears to 0 and blink_ph toggles.
// - Blink gating:
//   - BLINK=0 or BLINK_EN=0: blink_cnt held 0, blink_ph held 1.
//   - Any write to BLINK: blink_cnt cleared to 0, blink_ph set to 1 on the same edge.
// - Channel term:
//   - on[i] = MASK[i] & (MODE ? (pwm_cnt < DUTY[i]) : 1) & blink_ph
//   - DUTY=0 -> never on; DUTY=2**PWM_W-1 -> on (2**PWM_W-1) of 2**PWM_W clocks.
// - Output and EN:
//   - coe_led[i] <= on[i] ^ INV
//   - EN=0: pwm_cnt and blink_cnt cleared and held; coe_led <= {LED_W{INV}} (all LEDs dark).
// - Write to CTRL changing MODE: pwm_cnt not reset; new compare applies from the next edge.
// - Write to DUTY mid-period: new duty used immediately; a glitch of at most one PWM period is accepted.
// - Reset mid-operation: all state returns to reset values immediately; coe_led=0 even if INV was 1.
// CONFIGURATION
// - Macro: ZIRCON_LED_READBACK_EN
// - Defined:
//   - Adds ports avs_read (in, 1) and avs_readdata (out, 32).
//   - Fixed read latency of 1 clock: avs_readdata is registered and valid the clock after avs_read.
//   - Fields are zero-extended.
//   - Address 3 returns {blink_ph, pwm_cnt} status; unmapped addresses return 0.
//   - avs_readdata resets to 0.
// - Not defined: no read ports; the block is write-only; no other behaviour change.
// TESTING
// - Reset release: coe_led==0; write CTRL=1, MASK=8'hA5 -> coe_led==8'hA5 two edges after the write.
// - PWM: MODE=1, DUTY[0]=64, DUTY[1]=0, DUTY[2]=255, MASK=8'h07 -> over 256 clocks, ch0 high 64, ch1 0, ch2 255.
// - Blink: BLINK=10, BLINK_EN=1, static MASK=8'hFF -> coe_led alternates 8'hFF / 8'h00 every 10 clocks; BLINK write restarts in the on phase.
// - INV=1 with EN=0 -> coe_led==8'hFF; then EN=1, MASK=0 -> coe_led stays 8'hFF; assert reset -> coe_led==0 immediately.
// - Writes to addresses 3 and 12..15 -> no change to any output or register.
// - ZIRCON_LED_READBACK_EN: write DUTY[5]=8'h3C, read address 9 -> avs_readdata==32'h3C one clock after avs_read.

Source files
------------

// File: rtl/zircon_led_pwm_if.sv
// Avalon-MM slave bus bundle for the zircon_led_pwm LED controller.
// Read signals exist only when ZIRCON_LED_READBACK_EN is defined.
interface zircon_led_pwm_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
`ifdef ZIRCON_LED_READBACK_EN
  logic              avs_read;
  logic [31:0]       avs_readdata;
`endif

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata
`ifdef ZIRCON_LED_READBACK_EN
    ,
    output avs_read,
    input  avs_readdata
`endif
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata
`ifdef ZIRCON_LED_READBACK_EN
    ,
    input  avs_read,
    output avs_readdata
`endif
  );
endinterface

// File: rtl/zircon_led_pwm.sv
// Avalon-MM LED controller: per-channel PWM, global blink gate, output polarity.
// Optional register readback is enabled by defining ZIRCON_LED_READBACK_EN.
module zircon_led_pwm #(
  parameter int LED_W   = 8,
  parameter int PWM_W   = 8,
  parameter int BLINK_W = 24,
  parameter int ADDR_W  = 4
) (
  input  logic              csi_clk,
  input  logic              rsi_reset_n,
  zircon_led_pwm_if.slave   avs,
  output logic [LED_W-1:0]  coe_led
);

  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_MASK  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_BLINK = ADDR_W'(2);
  localparam int unsigned       DUTY_BASE = 4;

  logic [3:0]         ctrl_q, ctrl_d;
  logic [LED_W-1:0]   mask_q, mask_d;
  logic [BLINK_W-1:0] blink_q, blink_d;
  logic [PWM_W-1:0]   duty_q [LED_W];
  logic [PWM_W-1:0]   duty_d [LED_W];
  logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [LED_W-1:0]   on;

  logic en, mode, blink_en, inv, wr_blink, blink_run;

  assign en       = ctrl_q[0];
  assign mode     = ctrl_q[1];
  assign blink_en = ctrl_q[2];
  assign inv      = ctrl_q[3];
  assign wr_blink  = avs.avs_write && (avs.avs_address == A_BLINK);
  assign blink_run = en && blink_en && (blink_q != '0);

  // Only the low bits of each field are architected; the rest is dropped.
  logic unused_wdata;
  assign unused_wdata = ^avs.avs_writedata;

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    ctrl_d      = ctrl_q;
    mask_d      = mask_q;
    blink_d     = blink_q;
    duty_d      = duty_q;
    pwm_cnt_d   = '0;
    blink_cnt_d = '0;
    blink_ph_d  = 1'b1;
    on          = '0;

    if (avs.avs_write) begin
      if (avs.avs_address == A_CTRL) ctrl_d  = avs.avs_writedata[3:0];
      if (avs.avs_address == A_MASK) mask_d  = avs.avs_writedata[LED_W-1:0];
      if (wr_blink)                  blink_d = avs.avs_writedata[BLINK_W-1:0];
      for (int i = 0; i < LED_W; i++) begin
        if (32'(avs.avs_address) == 32'(DUTY_BASE + i))
          duty_d[i] = avs.avs_writedata[PWM_W-1:0];
      end
    end

    if (en) pwm_cnt_d = pwm_cnt_q + PWM_W'(1);

    // A BLINK write restarts the blink in the on phase, overriding the running count.
    if (!wr_blink && blink_run) begin
      if (blink_cnt_q == blink_q - BLINK_W'(1)) begin
        blink_ph_d = ~blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_ph_d  = blink_ph_q;
      end
    end

    for (int i = 0; i < LED_W; i++) begin
      on[i] = mask_q[i] & (mode ? (pwm_cnt_q < duty_q[i]) : 1'b1) & blink_ph_q;
    end
    led_d = en ? (on ^ {LED_W{inv}}) : {LED_W{inv}};
  end

  // NOTE: state uses non-blocking assignments; the duty array is reset too because
  // every register must read as zero after reset.
  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      ctrl_q      <= '0;
      mask_q      <= '0;
      blink_q     <= '0;
      duty_q      <= '{default: '0};
      pwm_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b1;
      led_q       <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      mask_q      <= mask_d;
      blink_q     <= blink_d;
      duty_q      <= duty_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      led_q       <= led_d;
    end
  end

  assign coe_led = led_q;

`ifdef ZIRCON_LED_READBACK_EN
  logic [31:0] rdata_q, rdata_d;

  // Address 3 is a status word; unmapped addresses read as zero.
  always_comb begin
    rdata_d = rdata_q;
    if (avs.avs_read) begin
      rdata_d = '0;
      case (avs.avs_address)
        A_CTRL:       rdata_d = 32'(ctrl_q);
        A_MASK:       rdata_d = 32'(mask_q);
        A_BLINK:      rdata_d = 32'(blink_q);
        ADDR_W'(3):   rdata_d = 32'({blink_ph_q, pwm_cnt_q});
        default: begin
          for (int i = 0; i < LED_W; i++) begin
            if (32'(avs.avs_address) == 32'(DUTY_BASE + i)) rdata_d = 32'(duty_q[i]);
          end
        end
      endcase
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) rdata_q <= '0;
    else              rdata_q <= rdata_d;
  end

  assign avs.avs_readdata = rdata_q;
`endif

endmodule

// File: tb/tb_zircon_led_pwm.sv
// Directed bench for zircon_led_pwm; expected values flow through a scoreboard queue.
module tb_zircon_led_pwm;
  localparam int LED_W   = 8;
  localparam int PWM_W   = 8;
  localparam int BLINK_W = 24;
  localparam int ADDR_W  = 4;

  logic             csi_clk = 1'b0;
  logic             rsi_reset_n = 1'b0;
  logic [LED_W-1:0] coe_led;

  zircon_led_pwm_if #(.ADDR_W(ADDR_W)) avs_if ();

  zircon_led_pwm #(
    .LED_W(LED_W), .PWM_W(PWM_W), .BLINK_W(BLINK_W), .ADDR_W(ADDR_W)
  ) dut (
    .csi_clk     (csi_clk),
    .rsi_reset_n (rsi_reset_n),
    .avs         (avs_if.slave),
    .coe_led     (coe_led)
  );

  always #5 csi_clk = ~csi_clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic push_exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %h expected <none queued>", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    @(negedge csi_clk);
    avs_if.avs_address   = ADDR_W'(addr);
    avs_if.avs_writedata = data;
    avs_if.avs_write     = 1'b1;
    @(negedge csi_clk);
    avs_if.avs_write     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int cnt [4];
    avs_if.avs_address   = '0;
    avs_if.avs_write     = 1'b0;
    avs_if.avs_writedata = '0;
`ifdef ZIRCON_LED_READBACK_EN
    avs_if.avs_read      = 1'b0;
`endif

    // Reset state
    #1;
    push_exp(32'h0);
    pop_check("reset_led", 32'(coe_led));
    @(negedge csi_clk);
    rsi_reset_n = 1'b1;

    // Static mode: MASK visible two edges after its write
    wr(0, 32'h1);
    push_exp(32'h00);
    push_exp(32'hA5);
    wr(1, 32'hA5);
    pop_check("mask_one_edge", 32'(coe_led));
    @(negedge csi_clk);
    pop_check("mask_two_edges", 32'(coe_led));

    // Reserved and unmapped writes are ignored
    push_exp(32'hA5);
    wr(3, 32'hFFFF_FFFF);
    for (int a = 12; a < 16; a++) wr(a, 32'hFFFF_FFFF);
    @(negedge csi_clk);
    @(negedge csi_clk);
    pop_check("unmapped_writes", 32'(coe_led));

    // PWM duty boundaries over one full 256-clock period
    push_exp(32'd64);
    push_exp(32'd0);
    push_exp(32'd255);
    push_exp(32'd0);
    wr(4, 32'd64);
    wr(5, 32'd0);
    wr(6, 32'hFFFF_FFFF);
    wr(1, 32'h07);
    wr(0, 32'h3);
    @(negedge csi_clk);
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge csi_clk);
      for (int c = 0; c < 4; c++) if (coe_led[c]) cnt[c]++;
    end
    pop_check("pwm_ch0_duty64", 32'(cnt[0]));
    pop_check("pwm_ch1_duty0", 32'(cnt[1]));
    pop_check("pwm_ch2_duty255", 32'(cnt[2]));
    pop_check("pwm_ch3_masked", 32'(cnt[3]));

    // Blink: 10 clocks on, 10 off
    wr(1, 32'hFF);
    wr(0, 32'h5);
    wr(2, 32'd10);
    for (int j = 1; j <= 15; j++) begin
      push_exp((((j - 1) / 10) % 2 == 0) ? 32'hFF : 32'h00);
      @(negedge csi_clk);
      pop_check("blink_phase", 32'(coe_led));
    end
    // BLINK rewrite during the off phase restarts in the on phase
    wr(2, 32'd10);
    for (int j = 1; j <= 12; j++) begin
      push_exp((j <= 10) ? 32'hFF : 32'h00);
      @(negedge csi_clk);
      pop_check("blink_restart", 32'(coe_led));
    end

    // Polarity: disabled with INV is all-dark (all ones)
    wr(2, 32'd0);
    wr(0, 32'h8);
    push_exp(32'hFF);
    @(negedge csi_clk);
    pop_check("inv_en0", 32'(coe_led));
    wr(1, 32'h0);
    wr(0, 32'h9);
    push_exp(32'hFF);
    @(negedge csi_clk);
    pop_check("inv_en1_mask0", 32'(coe_led));

`ifdef ZIRCON_LED_READBACK_EN
    wr(9, 32'h3C);
    push_exp(32'h3C);
    push_exp(32'h0);
    @(negedge csi_clk);
    avs_if.avs_address = ADDR_W'(9);
    avs_if.avs_read    = 1'b1;
    @(negedge csi_clk);
    avs_if.avs_address = ADDR_W'(12);
    pop_check("read_duty5", avs_if.avs_readdata);
    @(negedge csi_clk);
    avs_if.avs_read    = 1'b0;
    pop_check("read_unmapped", avs_if.avs_readdata);
`endif

    // Asynchronous reset forces the pins low even with INV set
    push_exp(32'h0);
    push_exp(32'h0);
    @(negedge csi_clk);
    #2;
    rsi_reset_n = 1'b0;
    #1;
    pop_check("reset_async", 32'(coe_led));
    @(negedge csi_clk);
    rsi_reset_n = 1'b1;
    @(negedge csi_clk);
    @(negedge csi_clk);
    pop_check("after_reset", 32'(coe_led));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
